// File: rtl/sift_img_pkg.sv
// sift_img_pkg: shared types and constants for the SIFT frame-buffer server.
//   state_t    - server FSM states (EMPTY, LOAD, SERVE)
//   IMG_PIXELS - pixel count of the default 512x512 frame
//   img_pixels - pixel count for an arbitrary frame geometry
package sift_img_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        SERVE
    } state_t;

    localparam int unsigned IMG_W_DEF  = 512;
    localparam int unsigned IMG_H_DEF  = 512;
    localparam int unsigned IMG_PIXELS = IMG_W_DEF * IMG_H_DEF;
    localparam int unsigned ADDR_W_DEF = $clog2(IMG_PIXELS);

    function automatic int unsigned img_pixels(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

endpackage

// File: rtl/sift_img_server_if.sv
// sift_img_server_if: pixel-stream and feature-pipeline fetch bus.
//   pix_in/pix_valid/pix_ready - upstream raster pixel stream (valid/ready)
//   addr_sift/img              - pipeline read address / registered pixel
//   complete2                  - pipeline finished both octaves
//   flag_read                  - 1 holds the pipeline in reset (no frame served)
// master: upstream source + feature pipeline side; slave: the frame server.
interface sift_img_server_if #(
    parameter int ADDR_W = 18
);
    logic [7:0]        pix_in;
    logic              pix_valid;
    logic              pix_ready;
    logic [ADDR_W-1:0] addr_sift;
    logic [7:0]        img;
    logic              complete2;
    logic              flag_read;

    modport master (
        output pix_in, pix_valid, addr_sift, complete2,
        input  pix_ready, img, flag_read
    );

    modport slave (
        input  pix_in, pix_valid, addr_sift, complete2,
        output pix_ready, img, flag_read
    );
endinterface

// File: rtl/sift_img_ram.sv
// sift_img_ram: simple dual-port RAM, one write port and one registered read
// port, 8 bit x 2**ADDR_W. Contents are not reset so it maps onto block RAM.
//   clk          - clock
//   we/wa/wd     - write enable, address, data
//   ra/rd        - read address, registered read data (1-cycle latency)
module sift_img_ram #(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [7:0]        wd,
    input  logic [ADDR_W-1:0] ra,
    output logic [7:0]        rd
);
    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        rd <= mem[ra];
    end
endmodule

// File: rtl/sift_img_server.sv
// sift_img_server: loads one 8-bit grayscale frame from a valid/ready pixel
// stream into on-chip RAM, then serves addr_sift reads until the feature
// pipeline signals completion with a complete2 rising edge.
//   clk, rst     - clock, asynchronous active-high reset
//   frame_start  - pulse: begin or restart loading a frame
//   bus          - pixel stream + fetch bus (slave side)
//   frame_done   - pulse when a served frame has been consumed
//   frame_cnt    - frames consumed since reset, wraps
module sift_img_server
    import sift_img_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    sift_img_server_if.slave      bus,
    output logic                  frame_done,
    output logic [7:0]            frame_cnt
);
    localparam int unsigned NPIX = img_pixels(IMG_W, IMG_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic              complete2_d;
    logic              pix_ready_q;
    logic              flag_read_q;
    logic              rd_ok;
    logic [7:0]        rd_data;

    logic              accept;
    logic [ADDR_W-1:0] wa;
    logic              in_range;
    logic              c2_rise;

    // A restart in the same cycle as an accepted pixel puts that pixel at 0.
    always_comb begin
        accept   = (state == LOAD) && bus.pix_valid && pix_ready_q;
        wa       = frame_start ? '0 : wr_addr;
        in_range = ({1'b0, bus.addr_sift} < (ADDR_W + 1)'(NPIX));
        c2_rise  = bus.complete2 && !complete2_d;
    end

    sift_img_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk (clk),
        .we  (accept),
        .wa  (wa),
        .wd  (bus.pix_in),
        .ra  (bus.addr_sift),
        .rd  (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            wr_addr     <= '0;
            complete2_d <= 1'b0;
            pix_ready_q <= 1'b0;
            flag_read_q <= 1'b1;
            rd_ok       <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            complete2_d <= bus.complete2;
            frame_done  <= 1'b0;
            rd_ok       <= 1'b0;
            unique case (state)
                EMPTY: begin
                    if (frame_start) begin
                        state       <= LOAD;
                        wr_addr     <= '0;
                        pix_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (wa == LAST_ADDR) begin
                            state       <= SERVE;
                            wr_addr     <= '0;
                            pix_ready_q <= 1'b0;
                            flag_read_q <= 1'b0;
                        end else begin
                            wr_addr <= wa + 1'b1;
                        end
                    end else if (frame_start) begin
                        wr_addr <= '0;
                    end
                end
                SERVE: begin
                    if (frame_start) begin
                        state       <= LOAD;
                        wr_addr     <= '0;
                        pix_ready_q <= 1'b1;
                        flag_read_q <= 1'b1;
                    end else if (c2_rise) begin
                        state       <= EMPTY;
                        flag_read_q <= 1'b1;
                        frame_done  <= 1'b1;
                        frame_cnt   <= frame_cnt + 1'b1;
                    end else begin
                        rd_ok <= in_range;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    pix_ready_q <= 1'b0;
                    flag_read_q <= 1'b1;
                end
            endcase
        end
    end

    // rd_data and rd_ok are both captured on the same edge, so img carries
    // the one-cycle read latency and is forced to 0 outside SERVE/out of range.
    assign bus.img       = rd_ok ? rd_data : '0;
    assign bus.pix_ready = pix_ready_q;
    assign bus.flag_read = flag_read_q;
endmodule

// File: doc/sift_img_server.md
# sift_img_server

Frame-buffer responder that sits on the far side of the SIFT pixel-fetch interface: it loads one 8-bit grayscale frame from an upstream valid/ready pixel stream into on-chip RAM, then answers the feature pipeline's `addr_sift` requests with `img` data. It drives `flag_read` to hold the feature pipeline in reset while a frame is absent or loading. It watches `complete2` to know when the current frame has been consumed.

## Interface
Parameters:
- `IMG_W`, 512, frame width in pixels (power of two)
- `IMG_H`, 512, frame height in lines
- `ADDR_W`, 18, address width; `IMG_W*IMG_H <= 2**ADDR_W`

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, same domain as the feature pipeline
- `rst`  in  1  asynchronous, active-high reset
- `frame_start`  in  1  single-cycle pulse: begin (or restart) loading a frame
- `pix_in`  in  8  upstream pixel, raster order
- `pix_valid`  in  1  `pix_in` valid
- `pix_ready`  out  1  block accepts a pixel this cycle
- `addr_sift`  in  ADDR_W  read address from the feature pipeline
- `img`  out  8  pixel at `addr_sift`, registered
- `complete2`  in  1  feature pipeline finished both octaves
- `flag_read`  out  1  1 = no frame being served; feature pipeline held in reset
- `frame_done`  out  1  single-cycle pulse when a served frame is consumed
- `frame_cnt`  out  8  frames consumed since reset, wraps 255→0

## Operation
- States: EMPTY, LOAD, SERVE.
- EMPTY: `pix_ready`=0, `flag_read`=1, `img`=0. On `frame_start`, go to LOAD and set `wr_addr`=0.
- LOAD: `pix_ready`=1, `flag_read`=1, `img`=0.
  - Each `pix_valid && pix_ready` cycle writes `RAM[wr_addr]` and increments `wr_addr`.
  - The write at `wr_addr == IMG_W*IMG_H-1` moves the block to SERVE.
  - `frame_start` during LOAD clears `wr_addr` to 0 and stays in LOAD. A pixel accepted in that same cycle is written to address 0 and `wr_addr` becomes 1.
- SERVE: `pix_ready`=0, `flag_read`=0.
  - Each cycle `img <= RAM[addr_sift]`.
  - Addresses `>= IMG_W*IMG_H` return 0 and write nothing.
- Leaving SERVE on a `complete2` rising edge (`complete2 && !complete2_d`):
  - go to EMPTY;
  - pulse `frame_done` for 1 cycle;
  - increment `frame_cnt`.
- `frame_start` in SERVE: go to LOAD with `wr_addr`=0, no `frame_done`, no count. If a `complete2` rising edge falls in the same cycle, `frame_start` wins.
- `complete2` level that is already high when SERVE is entered is not an edge. The edge detector register `complete2_d` runs in all states.
- Reset values: state=EMPTY, `wr_addr`=0, `pix_ready`=0, `flag_read`=1, `img`=0, `frame_done`=0, `frame_cnt`=0, `complete2_d`=0. RAM contents are not reset.
- Reset asserted mid-LOAD or mid-SERVE: the partial frame is discarded and outputs return to reset values immediately (asynchronous).

## Timing
- All outputs are registered; `pix_ready` and `flag_read` are decoded from the state register.
- Last pixel accepted at edge T:
  - after T: state=SERVE, `pix_ready`=0, `flag_read`=0;
  - `addr_sift` presented in cycle T+1 yields `img` after edge T+1 (that pixel included).
- Read latency is 1 cycle: `addr_sift` sampled at edge N, `img` valid after edge N.
- `complete2` rising at edge N (`complete2`=1, `complete2_d`=0):
  - after N: `frame_done`=1, `flag_read`=1, state=EMPTY, `frame_cnt` incremented;
  - after N+1: `frame_done`=0.
- `frame_start` at edge N: `pix_ready`=1 after N.
- Throughput: 1 pixel/cycle in LOAD, 1 read/cycle in SERVE.

## Structure
- Package `sift_img_pkg`: state enum {EMPTY, LOAD, SERVE}, constant `IMG_PIXELS = IMG_W*IMG_H`.
- Sub-module `sift_img_ram`: simple dual-port RAM (1 write port, 1 registered read port, 8 bit × `2**ADDR_W`), infers block RAM.
- Top: FSM, `wr_addr` counter, out-of-range read mask, `complete2` edge detector, `frame_cnt`.

## Test plan (IMG_W=IMG_H=16 for sim)
- Reset, then `frame_start` → `pix_ready`=1 next cycle and `flag_read` stays 1. Stream 256 pixels `pix_in=addr[7:0]^8'h5A` with `pix_valid` always 1 → `flag_read` falls the cycle after pixel 255, `pix_ready` falls together.
- In SERVE, sweep `addr_sift` 0..255 → `img` = `addr^8'h5A` one cycle later. `addr_sift=256` → `img`=0.
- Stream with `pix_valid` toggling 1,0,1,0 → only accepted beats are written; the readback matches the first case.
- Hold `complete2`=1 across entry to SERVE → no `frame_done`. Then drop it, raise it → one `frame_done` pulse, `frame_cnt`=1, `flag_read`=1.
- `frame_start` at pixel 100 of LOAD, then a full 256-pixel stream → readback equals the second stream only.
- Assert `rst` mid-SERVE → `flag_read`=1, `img`=0, `frame_cnt`=0 immediately. `frame_start` then works normally.
